// File: rtl/tv80_dbg_pkg.sv
// Shared TV80 debug definitions: register-pair indices and the dump/restore state encoding.
package tv80_dbg_pkg;

  localparam int TV80_REG_PAIRS = 8;

  localparam logic [2:0] REG_BC = 3'd0;
  localparam logic [2:0] REG_DE = 3'd1;
  localparam logic [2:0] REG_HL = 3'd2;
  localparam logic [2:0] REG_IX = 3'd3;
  localparam logic [2:0] REG_IY = 3'd7;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SEND0 = 3'd2;
  localparam logic [2:0] ST_SEND1 = 3'd3;
  localparam logic [2:0] ST_FIN   = 3'd4;
  localparam logic [2:0] ST_RCV0  = 3'd5;
  localparam logic [2:0] ST_RCV1  = 3'd6;
  localparam logic [2:0] ST_WRITE = 3'd7;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    LOAD  = ST_LOAD,
    SEND0 = ST_SEND0,
    SEND1 = ST_SEND1,
    FIN   = ST_FIN,
    RCV0  = ST_RCV0,
    RCV1  = ST_RCV1,
    WRITE = ST_WRITE
  } dumpState_t;

  // Byte of a register pair that goes on the wire in slot 0 or slot 1.
  function automatic logic [7:0] pairByte(input logic [7:0] hi, input logic [7:0] lo,
                                          input logic highFirst, input logic second);
    return (highFirst ^ second) ? hi : lo;
  endfunction

endpackage

// File: rtl/tv80_reg_dump_if.sv
// Register-file ports and the dump/restore byte streams of tv80_reg_dump.
interface tv80_reg_dump_if;

  logic [2:0] rd_addr;
  logic [7:0] rd_dh;
  logic [7:0] rd_dl;

  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  logic [2:0] wr_addr;
  logic       wr_en;
  logic [7:0] wr_dh;
  logic [7:0] wr_dl;

  modport master (
    output rd_addr, input rd_dh, input rd_dl,
    output out_data, output out_valid, output out_last, input out_ready,
    input in_data, input in_valid, output in_ready,
    output wr_addr, output wr_en, output wr_dh, output wr_dl
  );

  modport slave (
    input rd_addr, output rd_dh, output rd_dl,
    input out_data, input out_valid, input out_last, output out_ready,
    output in_data, output in_valid, input in_ready,
    input wr_addr, input wr_en, input wr_dh, input wr_dl
  );

endinterface

// File: rtl/tv80_reg_dump.sv
// Streams TV80 register pairs out as bytes while the CPU is stopped.
// Define TV80_REG_RESTORE_EN to add the restore path through the register-file write port.
module tv80_reg_dump
  import tv80_dbg_pkg::*;
#(
  parameter int NUM_REGS   = TV80_REG_PAIRS,
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic cpu_stop,
  input  logic start,
  input  logic rst_start,
  output logic busy,
  output logic done,
  output logic abort,
  tv80_reg_dump_if.master bus
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_REGS - 1);

  dumpState_t state, stateNext;
  logic [2:0] idx, idxNext;
  logic [7:0] holdH, holdL, holdHNext, holdLNext;
  logic       abortQ;
  logic       lastPair;
  logic       killed;

  assign lastPair = (idx == LAST_IDX);
  // Losing cpu_stop means the register file may change under us: drop everything.
  assign killed   = (state != IDLE) && !cpu_stop;

  always_comb begin
    // NOTE: every target gets a default first so no path through the case infers a latch.
    stateNext = state;
    idxNext   = idx;
    holdHNext = holdH;
    holdLNext = holdL;
    if (killed) begin
      stateNext = IDLE;
      idxNext   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && cpu_stop) begin
            stateNext = LOAD;
            idxNext   = '0;
          end
`ifdef TV80_REG_RESTORE_EN
          else if (rst_start && cpu_stop) begin
            stateNext = RCV0;
            idxNext   = '0;
          end
`endif
        end
        LOAD: begin
          holdHNext = bus.rd_dh;
          holdLNext = bus.rd_dl;
          stateNext = SEND0;
        end
        SEND0: if (bus.out_ready) stateNext = SEND1;
        SEND1: begin
          if (bus.out_ready) begin
            if (lastPair) begin
              stateNext = FIN;
            end else begin
              idxNext   = idx + 3'd1;
              stateNext = LOAD;
            end
          end
        end
        FIN: stateNext = IDLE;
`ifdef TV80_REG_RESTORE_EN
        RCV0: begin
          if (bus.in_valid) begin
            if (HIGH_FIRST) holdHNext = bus.in_data;
            else            holdLNext = bus.in_data;
            stateNext = RCV1;
          end
        end
        RCV1: begin
          if (bus.in_valid) begin
            if (HIGH_FIRST) holdLNext = bus.in_data;
            else            holdHNext = bus.in_data;
            stateNext = WRITE;
          end
        end
        WRITE: begin
          if (lastPair) begin
            stateNext = FIN;
          end else begin
            idxNext   = idx + 3'd1;
            stateNext = RCV0;
          end
        end
`endif
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      idx    <= '0;
      // NOTE: the holding registers are reset because they drive visible outputs.
      holdH  <= '0;
      holdL  <= '0;
      abortQ <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register updates from the same pre-edge values.
      state  <= stateNext;
      idx    <= idxNext;
      holdH  <= holdHNext;
      holdL  <= holdLNext;
      abortQ <= killed;
    end
  end

  always_comb begin
    busy          = (state != IDLE);
    done          = (state == FIN) && cpu_stop;
    abort         = abortQ;
    bus.rd_addr   = idx;
    bus.out_valid = ((state == SEND0) || (state == SEND1)) && cpu_stop;
    bus.out_last  = (state == SEND1) && lastPair && cpu_stop;
    bus.out_data  = '0;
    if (state == SEND0)      bus.out_data = pairByte(holdH, holdL, HIGH_FIRST, 1'b0);
    else if (state == SEND1) bus.out_data = pairByte(holdH, holdL, HIGH_FIRST, 1'b1);
  end

`ifdef TV80_REG_RESTORE_EN
  assign bus.in_ready = ((state == RCV0) || (state == RCV1)) && cpu_stop;
  assign bus.wr_en    = (state == WRITE) && cpu_stop;
  assign bus.wr_addr  = (state == WRITE) ? idx : 3'd0;
  assign bus.wr_dh    = holdH;
  assign bus.wr_dl    = holdL;
`else
  assign bus.in_ready = 1'b0;
  assign bus.wr_en    = 1'b0;
  assign bus.wr_addr  = 3'd0;
  assign bus.wr_dh    = 8'd0;
  assign bus.wr_dl    = 8'd0;

  logic unusedRestore;
  assign unusedRestore = ^{rst_start, bus.in_data, bus.in_valid};
`endif

endmodule

// File: tb/tb_tv80_reg_dump.sv
// Self-checking bench for tv80_reg_dump: a behavioural register file plus byte-order reference model.
module tb_tv80_reg_dump;
  import tv80_dbg_pkg::*;

  localparam int NUM_REGS   = TV80_REG_PAIRS;
  localparam bit HIGH_FIRST = 1'b1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic cpu_stop = 1'b0;
  logic start = 1'b0;
  logic rst_start = 1'b0;
  logic busy, done, abort;

  tv80_reg_dump_if bus();

  tv80_reg_dump #(.NUM_REGS(NUM_REGS), .HIGH_FIRST(HIGH_FIRST)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_stop(cpu_stop), .start(start), .rst_start(rst_start),
    .busy(busy), .done(done), .abort(abort), .bus(bus)
  );

  always #5 clk = ~clk;

  // Behavioural register file: combinational read port C, synchronous write port A.
  logic [15:0] regs [8];
  logic [15:0] preload [8];
  logic        doPreload = 1'b0;

  always @(posedge clk) begin
    if (doPreload) begin
      for (int i = 0; i < 8; i++) regs[i] <= preload[i];
    end else if (bus.wr_en) begin
      regs[bus.wr_addr] <= {bus.wr_dh, bus.wr_dl};
    end
  end

  assign bus.rd_dh = regs[bus.rd_addr][15:8];
  assign bus.rd_dl = regs[bus.rd_addr][7:0];

  int nCmp  = 0;
  int nFail = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_regs();
    doPreload = 1'b1;
    tick();
    doPreload = 1'b0;
  endtask

  // mode 0: ready held 1, 1: ready toggles per cycle, 2: random ready.
  // dropAfter >= 0: cpu_stop falls in the cycle after that many bytes were accepted.
  task automatic do_dump(input int mode, input int dropAfter, input string tag);
    logic [7:0] expQ[$];
    logic [7:0] stallData;
    int  got, firstValid, lastAccept, cyc;
    bit  sawDone, stalled, dropped;
    got = 0; firstValid = -1; lastAccept = -1; cyc = 1;
    sawDone = 1'b0; stalled = 1'b0; dropped = 1'b0; stallData = '0;
    for (int p = 0; p < NUM_REGS; p++) begin
      if (HIGH_FIRST) begin
        expQ.push_back(regs[p][15:8]);
        expQ.push_back(regs[p][7:0]);
      end else begin
        expQ.push_back(regs[p][7:0]);
        expQ.push_back(regs[p][15:8]);
      end
    end
    cpu_stop = 1'b1;
    bus.out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 400 && !sawDone && !dropped; k++) begin
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'(cyc % 2);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      if (dropAfter >= 0 && got == dropAfter) begin
        cpu_stop = 1'b0;
        dropped  = 1'b1;
      end
      #1;
      if (!dropped) begin
        if (bus.out_valid) begin
          if (firstValid < 0) firstValid = cyc;
          if (stalled) chk({tag, "_stall_data"}, 16'(bus.out_data), 16'(stallData));
          chk({tag, "_last"}, 16'(bus.out_last), 16'(got == 2 * NUM_REGS - 1));
          if (bus.out_ready) begin
            chk({tag, "_byte"}, 16'(bus.out_data), 16'((got < expQ.size()) ? expQ[got] : 8'hxx));
            lastAccept = cyc;
            got++;
            stalled = 1'b0;
          end else begin
            stalled   = 1'b1;
            stallData = bus.out_data;
          end
        end else begin
          stalled = 1'b0;
        end
        if (done) begin
          sawDone = 1'b1;
          chk({tag, "_done_latency"}, 16'(cyc), 16'(lastAccept + 1));
          chk({tag, "_byte_count"}, 16'(got), 16'(2 * NUM_REGS));
        end else begin
          @(posedge clk);
          #1;
          cyc++;
        end
      end
    end
    if (dropped) begin
      @(posedge clk);
      #2;
      chk({tag, "_abort_pulse"}, 16'(abort), 16'd1);
      chk({tag, "_abort_busy"}, 16'(busy), 16'd0);
      chk({tag, "_abort_no_done"}, 16'(done), 16'd0);
      chk({tag, "_abort_valid"}, 16'(bus.out_valid), 16'd0);
      @(posedge clk);
      #2;
      chk({tag, "_abort_once"}, 16'(abort), 16'd0);
      chk({tag, "_abort_no_done2"}, 16'(done), 16'd0);
      chk({tag, "_abort_bytes"}, 16'(got), 16'(dropAfter));
      cpu_stop = 1'b1;
    end else begin
      chk({tag, "_done_seen"}, 16'(sawDone), 16'd1);
      chk({tag, "_first_valid"}, 16'(firstValid), 16'd2);
      if (mode == 0) chk({tag, "_pair_rate"}, 16'(lastAccept), 16'(3 * NUM_REGS));
      @(posedge clk);
      #2;
      chk({tag, "_done_one_cycle"}, 16'(done), 16'd0);
      chk({tag, "_idle_after"}, 16'(busy), 16'd0);
    end
  endtask

  task automatic load_directed();
    preload[REG_BC] = 16'h1234;
    preload[REG_DE] = 16'h5678;
    preload[REG_HL] = 16'h9ABC;
    preload[REG_IX] = 16'hDEF0;
    preload[4]      = 16'h1357;
    preload[5]      = 16'h2468;
    preload[6]      = 16'hACE0;
    preload[REG_IY] = 16'hF00F;
    load_regs();
  endtask

  initial begin
    bus.out_ready = 1'b0;
    bus.in_data   = 8'd0;
    bus.in_valid  = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_abort", 16'(abort), 16'd0);
    chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
    chk("rst_out_last", 16'(bus.out_last), 16'd0);
    chk("rst_out_data", 16'(bus.out_data), 16'd0);
    chk("rst_rd_addr", 16'(bus.rd_addr), 16'd0);
    chk("rst_in_ready", 16'(bus.in_ready), 16'd0);
    chk("rst_wr_en", 16'(bus.wr_en), 16'd0);
    chk("rst_wr_addr", 16'(bus.wr_addr), 16'd0);
    chk("rst_wr_dh", 16'(bus.wr_dh), 16'd0);
    chk("rst_wr_dl", 16'(bus.wr_dl), 16'd0);
    reset_n = 1'b1;
    tick();

    // Directed dump, ready held high
    load_directed();
    do_dump(0, -1, "dump_directed");

    // Ready toggling every cycle
    do_dump(1, -1, "dump_toggle");

    // start without cpu_stop is ignored
    cpu_stop = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) begin
      #1;
      chk("nostop_busy", 16'(busy), 16'd0);
      chk("nostop_valid", 16'(bus.out_valid), 16'd0);
      tick();
    end

    // Random register contents with random back-pressure
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) preload[i] = 16'($urandom);
      cpu_stop = 1'b1;
      load_regs();
      do_dump(2, -1, "dump_random");
    end

    // cpu_stop drops after the 5th accepted byte
    do_dump(2, 5, "abort");
    tick();

    // Async reset while the second byte is on the wire
    load_directed();
    cpu_stop = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    bus.out_ready = 1'b0;
    #1;
    chk("rst_mid_valid_before", 16'(bus.out_valid), 16'd1);
    chk("rst_mid_data_before", 16'(bus.out_data), 16'h34);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_valid", 16'(bus.out_valid), 16'd0);
    chk("rst_mid_busy", 16'(busy), 16'd0);
    chk("rst_mid_last", 16'(bus.out_last), 16'd0);
    #2;
    reset_n = 1'b1;
    tick();
    do_dump(0, -1, "after_reset");

`ifdef TV80_REG_RESTORE_EN
    begin
      int  nWr, sent;
      bit  fin;
      nWr = 0; sent = 0; fin = 1'b0;
      cpu_stop = 1'b1;
      rst_start = 1'b1;
      tick();
      rst_start = 1'b0;
      for (int k = 0; k < 400 && !fin; k++) begin
        bus.in_valid = (sent < 2 * NUM_REGS) ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.in_data  = (sent % 2 == 0) ? 8'hAB : 8'hCD;
        #1;
        if (bus.wr_en) begin
          chk("restore_wr_addr", 16'(bus.wr_addr), 16'(nWr));
          chk("restore_wr_dh", 16'(bus.wr_dh), 16'hAB);
          chk("restore_wr_dl", 16'(bus.wr_dl), 16'hCD);
          nWr++;
        end
        if (bus.in_valid && bus.in_ready) sent++;
        if (done) fin = 1'b1;
        else begin
          @(posedge clk);
          #1;
        end
      end
      bus.in_valid = 1'b0;
      chk("restore_done", 16'(fin), 16'd1);
      chk("restore_writes", 16'(nWr), 16'(NUM_REGS));
      tick();
      do_dump(0, -1, "after_restore");
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
